// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the data-memory responder and its storage array.
package mips_mem_pkg;

    localparam int unsigned WORD_W        = 32;
    localparam int unsigned DEPTH_DEFAULT = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/data_mem_array.sv
// Single-port word storage: synchronous write, combinational read.
module data_mem_array
    import mips_mem_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT,
    parameter int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    // Contents are never reset; the initializer only fixes the simulation start state.
    logic [WORD_W-1:0] mem_q [DEPTH] = '{default: '0};

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    always_comb begin
        rdata = mem_q[addr];
    end

endmodule

// File: rtl/data_mem_responder.sv
// Wait-state data-memory responder: accepts one request, waits WAIT_CYCLES, then pulses a response.
module data_mem_responder
    import mips_mem_pkg::*;
#(
    parameter int unsigned DEPTH       = DEPTH_DEFAULT,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        ReqValid,
    input  logic        ReqWrite,
    input  logic [31:0] ReqAddr,
    input  logic [31:0] ReqWData,
    output logic        ReqReady,
    output logic        RespValid,
    output logic [31:0] RespRData,
    output logic        RespErr
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              ready_q, ready_d;
    logic              valid_q, valid_d;
    logic [WORD_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              write_q, write_d;
    logic [31:0]       addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;

    logic              cur_write;
    logic [31:0]       cur_addr;
    logic [WORD_W-1:0] cur_wdata;
    logic              cur_err;
    logic              mem_we;
    logic [WORD_W-1:0] mem_rdata;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        valid_d = 1'b0;
        rdata_d = '0;
        err_d   = 1'b0;
        mem_we  = 1'b0;

        // With zero wait states RESP is entered on the accept edge itself,
        // so the live request fields stand in for the not-yet-latched ones.
        if (state_q == IDLE) begin
            cur_write = ReqWrite;
            cur_addr  = ReqAddr;
            cur_wdata = ReqWData;
        end else begin
            cur_write = write_q;
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
        end
        cur_err = (cur_addr[1:0] != 2'b00) || (cur_addr[31:2] >= 30'(DEPTH));

        case (state_q)
            IDLE: begin
                if (ReqValid && ready_q) begin
                    write_d = ReqWrite;
                    addr_d  = ReqAddr;
                    wdata_d = ReqWData;
                    if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(WAIT_CYCLES - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (state_d == RESP) begin
            valid_d = 1'b1;
            err_d   = cur_err;
            mem_we  = cur_write && !cur_err && !Reset;
            if (!cur_write && !cur_err) begin
                rdata_d = mem_rdata;
            end
        end

        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    data_mem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk   (Clk),
        .we    (mem_we),
        .addr  (cur_addr[IDX_W+1:2]),
        .wdata (cur_wdata),
        .rdata (mem_rdata)
    );

    assign ReqReady  = ready_q;
    assign RespValid = valid_q;
    assign RespRData = rdata_q;
    assign RespErr   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: a WAIT_CYCLES=2 instance for timing/data/error/reset cases, a WAIT_CYCLES=0 instance for throughput.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        Reset = 1'b1;

    logic        a_valid = 1'b0, a_write = 1'b0;
    logic [31:0] a_addr = '0, a_wdata = '0;
    logic        a_ready, a_rvalid, a_err;
    logic [31:0] a_rdata;

    logic        z_valid = 1'b0, z_write = 1'b0;
    logic [31:0] z_addr = '0, z_wdata = '0;
    logic        z_ready, z_rvalid, z_err;
    logic [31:0] z_rdata;

    int unsigned total_cnt = 0;
    int unsigned pass_cnt  = 0;
    int unsigned fail_cnt  = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH(64), .WAIT_CYCLES(2)) dut_w2 (
        .Clk(clk), .Reset(Reset),
        .ReqValid(a_valid), .ReqWrite(a_write), .ReqAddr(a_addr), .ReqWData(a_wdata),
        .ReqReady(a_ready), .RespValid(a_rvalid), .RespRData(a_rdata), .RespErr(a_err)
    );

    data_mem_responder #(.DEPTH(64), .WAIT_CYCLES(0)) dut_w0 (
        .Clk(clk), .Reset(Reset),
        .ReqValid(z_valid), .ReqWrite(z_write), .ReqAddr(z_addr), .ReqWData(z_wdata),
        .ReqReady(z_ready), .RespValid(z_rvalid), .RespRData(z_rdata), .RespErr(z_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One request on the WAIT_CYCLES=2 instance: response expected in the 3rd cycle after accept.
    task automatic req_w2(input string tag, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata,
                          input logic exp_err);
        a_valid = 1'b1; a_write = wr; a_addr = addr; a_wdata = wdata;
        check({tag, " ready_before"}, 32'(a_ready), 32'd1);
        step();
        a_valid = 1'b0; a_write = 1'b0; a_addr = '0; a_wdata = '0;
        check({tag, " c1_ready"}, 32'(a_ready), 32'd0);
        check({tag, " c1_valid"}, 32'(a_rvalid), 32'd0);
        step();
        check({tag, " c2_ready"}, 32'(a_ready), 32'd0);
        check({tag, " c2_valid"}, 32'(a_rvalid), 32'd0);
        step();
        check({tag, " c3_ready"}, 32'(a_ready), 32'd0);
        check({tag, " c3_valid"}, 32'(a_rvalid), 32'd1);
        check({tag, " c3_rdata"}, a_rdata, exp_rdata);
        check({tag, " c3_err"}, 32'(a_err), 32'(exp_err));
        step();
        check({tag, " c4_ready"}, 32'(a_ready), 32'd1);
        check({tag, " c4_valid"}, 32'(a_rvalid), 32'd0);
        check({tag, " c4_rdata"}, a_rdata, 32'd0);
        check({tag, " c4_err"}, 32'(a_err), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held for two edges.
        step();
        step();
        Reset = 1'b0;
        check("rst ready", 32'(a_ready), 32'd1);
        check("rst valid", 32'(a_rvalid), 32'd0);
        check("rst rdata", a_rdata, 32'd0);
        check("rst err", 32'(a_err), 32'd0);
        check("rst z_ready", 32'(z_ready), 32'd1);
        check("rst z_valid", 32'(z_rvalid), 32'd0);

        req_w2("st10", 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        req_w2("ld10", 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

        req_w2("ld12_misal", 1'b0, 32'h12, 32'h0, 32'h0, 1'b1);
        req_w2("st0", 1'b1, 32'h0, 32'hCAFEF00D, 32'h0, 1'b0);
        // Word 64 would alias onto word 0 if the index were truncated.
        req_w2("st100_oor", 1'b1, 32'h100, 32'h1, 32'h0, 1'b1);
        req_w2("ld0_prior", 1'b0, 32'h0, 32'h0, 32'hCAFEF00D, 1'b0);
        req_w2("stFC", 1'b1, 32'hFC, 32'h12345678, 32'h0, 1'b0);
        req_w2("ldFC", 1'b0, 32'hFC, 32'h0, 32'h12345678, 1'b0);
        req_w2("ld10_again", 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

        // Store abandoned by reset during its second wait cycle.
        a_valid = 1'b1; a_write = 1'b1; a_addr = 32'h20; a_wdata = 32'h55;
        step();
        a_valid = 1'b0; a_write = 1'b0; a_addr = '0; a_wdata = '0;
        step();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        check("abort valid", 32'(a_rvalid), 32'd0);
        check("abort ready", 32'(a_ready), 32'd1);
        step();
        check("abort valid_after", 32'(a_rvalid), 32'd0);
        req_w2("ld20_old", 1'b0, 32'h20, 32'h0, 32'h0, 1'b0);

        // Zero wait states, ReqValid held high: store then back-to-back loads.
        z_valid = 1'b1; z_write = 1'b1; z_addr = 32'h8; z_wdata = 32'h0000A5A5;
        check("z k0 ready", 32'(z_ready), 32'd1);
        step();
        z_write = 1'b0; z_wdata = '0;
        check("z k1 valid", 32'(z_rvalid), 32'd1);
        check("z k1 ready", 32'(z_ready), 32'd0);
        check("z k1 rdata", z_rdata, 32'd0);
        check("z k1 err", 32'(z_err), 32'd0);
        for (int k = 2; k < 12; k++) begin
            step();
            check($sformatf("z k%0d valid", k), 32'(z_rvalid), (k % 2 == 1) ? 32'd1 : 32'd0);
            check($sformatf("z k%0d ready", k), 32'(z_ready), (k % 2 == 1) ? 32'd0 : 32'd1);
            check($sformatf("z k%0d rdata", k), z_rdata, (k % 2 == 1) ? 32'h0000A5A5 : 32'd0);
        end
        z_valid = 1'b0; z_addr = '0;
        step();
        step();
        check("z idle valid", 32'(z_rvalid), 32'd0);
        check("z idle ready", 32'(z_ready), 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
